enc_stage_1: RTL and testbench

- Front stage of the extended-Hamming encoder. It takes an info word and a mode, and builds the codeword with the info field and the Hamming parity bits in place.
- The overall-parity slot at index P-1 is left at 0. The downstream stage fills it and registers the final codeword.
- Parity bits are computed serially, one H-matrix row per cycle. Valid/ready handshakes are used on both sides.

---
 rtl/enc_pkg.sv | 39 +++
 rtl/enc_row_parity.sv | 13 +
 rtl/enc_stage_1.sv | 101 ++++++++++
 tb/tb_enc_stage_1.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: widths, mode/state encodings, H-matrix rows and field masks for the extended-Hamming encoder.
package enc_pkg;

    localparam int MAX_CODEWORD_WIDTH = 32;
    localparam int MAX_INFO_WIDTH     = 26;
    localparam int MAX_PARITY_WIDTH   = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

    typedef enum logic [1:0] {MOD_8_4, MOD_16_11, MOD_32_26, MOD_ILLEGAL} mod_t;
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    // Row r of mode m; unused leading rows of the short codes are zero.
    localparam logic [MAX_CODEWORD_WIDTH-1:0] H_ROW [3][6] = '{
        '{32'h0, 32'h0, 32'h0, 32'h000000E4, 32'h000000D2, 32'h000000B1},
        '{32'h0, 32'h0, 32'h0000FE08, 32'h0000F1C4, 32'h0000CDA2, 32'h0000AB61},
        '{32'h0, 32'hFFFE0010, 32'hFF01FC08, 32'hF0F1E384, 32'hCCCD9B42, 32'hAAAB56C1}
    };

    function automatic logic [4:0] k_of(input mod_t m);
        return m == MOD_8_4 ? 5'd4 : m == MOD_16_11 ? 5'd11 : m == MOD_32_26 ? 5'd26 : 5'd0;
    endfunction

    function automatic logic [2:0] p_of(input mod_t m);
        return m == MOD_8_4 ? 3'd4 : m == MOD_16_11 ? 3'd5 : m == MOD_32_26 ? 3'd6 : 3'd0;
    endfunction

    function automatic logic [MAX_CODEWORD_WIDTH-1:0] info_mask(input mod_t m);
        return ((32'd1 << k_of(m)) - 32'd1) << p_of(m);
    endfunction

    // Hamming parity slots [P-2:0]; the overall-parity slot P-1 is excluded.
    function automatic logic [MAX_CODEWORD_WIDTH-1:0] parity_mask(input mod_t m);
        return ((32'd1 << p_of(m)) - 32'd1) >> 1;
    endfunction

    function automatic logic [MAX_CODEWORD_WIDTH-1:0] h_row(input mod_t m, input logic [2:0] r);
        return (m == MOD_ILLEGAL || r > 3'd5) ? '0 : H_ROW[m][r];
    endfunction

endpackage

// File: rtl/enc_row_parity.sv
// enc_row_parity: XOR-reduction of a codeword restricted to one H-matrix row and the info field.
module enc_row_parity
    import enc_pkg::*;
(
    input  logic [MAX_CODEWORD_WIDTH-1:0] code,
    input  logic [MAX_CODEWORD_WIDTH-1:0] row,
    input  logic [MAX_CODEWORD_WIDTH-1:0] mask,
    output logic                          parity
);

    assign parity = ^(code & row & mask);

endmodule

// File: rtl/enc_stage_1.sv
// enc_stage_1: front stage of the extended-Hamming encoder; places info bits and Hamming parity.
// Define ENC_STAGE_1_PARALLEL_EN to compute all parity bits at acceptance instead of serially.
module enc_stage_1
    import enc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     info_in,
    input  logic [1:0]                    mod_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    mod_out,
    output logic                          illegal_mod
);

    state_t                        state, state_nx;
    mod_t                          m_in, mod_q, mod_nx;
    logic [MAX_CODEWORD_WIDTH-1:0] skel, load, data_q, data_nx;
    logic [2:0]                    j_q, j_nx;

    assign m_in = mod_t'(mod_in);
    assign skel = ({{MAX_PARITY_WIDTH{1'b0}}, info_in} << p_of(m_in)) & info_mask(m_in);

`ifdef ENC_STAGE_1_PARALLEL_EN
    localparam state_t ACC = OUT;
    logic [MAX_PARITY_WIDTH-2:0] par;
    for (genvar i = 0; i < MAX_PARITY_WIDTH - 1; i++) begin : g_par
        enc_row_parity u_row (
            .code   (skel),
            .row    (h_row(m_in, 3'(5 - i))),
            .mask   (info_mask(m_in)),
            .parity (par[i])
        );
    end
    assign load = skel | (32'(par) & parity_mask(m_in));
`else
    localparam state_t ACC = CALC;
    logic par_bit;
    enc_row_parity u_row (
        .code   (data_q),
        .row    (h_row(mod_q, 3'd5 - j_q)),
        .mask   (info_mask(mod_q)),
        .parity (par_bit)
    );
    assign load = skel;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            data_q <= '0;
            mod_q  <= MOD_8_4;
            j_q    <= '0;
        end else begin
            data_q <= data_nx;
            mod_q  <= mod_nx;
            j_q    <= j_nx;
        end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? (m_in == MOD_ILLEGAL ? OUT : ACC) : IDLE;
            CALC:    state_nx = (j_q == p_of(mod_q) - 3'd2) ? OUT : CALC;
            OUT:     state_nx = out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        data_nx = data_q;
        mod_nx  = mod_q;
        j_nx    = j_q;
        if (state == IDLE && in_valid) begin
            data_nx = load;
            mod_nx  = m_in;
            j_nx    = '0;
        end
`ifndef ENC_STAGE_1_PARALLEL_EN
        else if (state == CALC) begin
            data_nx = data_q | (32'(par_bit) << j_q);
            j_nx    = j_q + 3'd1;
        end
`endif
    end

    always_comb begin
        in_ready    = state == IDLE;
        out_valid   = state == OUT;
        illegal_mod = state == OUT && mod_q == MOD_ILLEGAL;
        data_out    = data_q;
        mod_out     = mod_q;
    end

endmodule

// File: tb/tb_enc_stage_1.sv
// tb_enc_stage_1: randomized bench for enc_stage_1 against a bit-level behavioural encoder model.
module tb_enc_stage_1;

    logic        clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic [25:0] info_in = '0;
    logic [1:0]  mod_in = '0;
    logic        in_ready, out_valid, illegal_mod;
    logic [31:0] data_out;
    logic [1:0]  mod_out;

    int          tests = 0, fails = 0;
    logic        exp_live = 0;
    logic [31:0] exp_data = '0;
    logic [1:0]  exp_mod = '0;

`ifdef ENC_STAGE_1_PARALLEL_EN
    localparam bit PAR = 1;
`else
    localparam bit PAR = 0;
`endif

    always #5 clk = ~clk;

    enc_stage_1 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .info_in     (info_in),
        .mod_in      (mod_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .mod_out     (mod_out),
        .illegal_mod (illegal_mod)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int k_of(input logic [1:0] m);
        return m == 0 ? 4 : m == 1 ? 11 : m == 2 ? 26 : 0;
    endfunction

    function automatic int p_of(input logic [1:0] m);
        return m == 0 ? 4 : m == 1 ? 5 : m == 2 ? 6 : 0;
    endfunction

    function automatic logic [31:0] hrow(input int m, input int r);
        case (m * 8 + r)
            3:  return 32'h000000E4;
            4:  return 32'h000000D2;
            5:  return 32'h000000B1;
            10: return 32'h0000FE08;
            11: return 32'h0000F1C4;
            12: return 32'h0000CDA2;
            13: return 32'h0000AB61;
            17: return 32'hFFFE0010;
            18: return 32'hFF01FC08;
            19: return 32'hF0F1E384;
            20: return 32'hCCCD9B42;
            21: return 32'hAAAB56C1;
            default: return 32'h0;
        endcase
    endfunction

    // Place info bits one by one, then count row hits over the info field for each parity bit.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [25:0] info);
        logic [31:0] cw, row;
        int k, p, ones;
        k  = k_of(m);
        p  = p_of(m);
        cw = '0;
        for (int b = 0; b < k; b++) cw[p + b] = info[b];
        for (int j = 0; j < p - 1; j++) begin
            row  = hrow(m, 5 - j);
            ones = 0;
            for (int b = p; b < p + k; b++) if (cw[b] && row[b]) ones++;
            cw[j] = ones[0];
        end
        return cw;
    endfunction

    always @(negedge clk)
        if (rst && out_valid) begin
            if (!exp_live) check("unexpected_out_valid", {31'b0, out_valid}, {31'b0, exp_live});
            else begin
                check("data_out", data_out, exp_data);
                check("mod_out", {30'b0, mod_out}, {30'b0, exp_mod});
                check("illegal_mod", {31'b0, illegal_mod}, {31'b0, exp_mod == 2'b11});
                check("in_ready_in_out", {31'b0, in_ready}, 32'd0);
            end
        end

    task automatic send(input logic [1:0] m, input logic [25:0] info, input int hold,
                        input bit use_lit, input logic [31:0] lit);
        int lat, exp_lat;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid  = 1;
        info_in   = info;
        mod_in    = m;
        out_ready = 1'($urandom);
        @(posedge clk);
        #1;
        in_valid = 0;
        info_in  = 26'($urandom);
        mod_in   = 2'($urandom);
        exp_data = model(m, info);
        exp_mod  = m;
        exp_live = 1;
        exp_lat  = (m == 2'b11 || PAR) ? 0 : p_of(m) - 1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        if (!out_valid) begin
            exp_live = 0;
            return;
        end
        if (use_lit) check("literal_data", data_out, lit);
        if (hold > 0) begin
            out_ready = 0;
            in_valid  = 1;
            info_in   = 26'($urandom);
            mod_in    = 2'($urandom);
            repeat (hold) @(posedge clk);
            #1;
            in_valid = 0;
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        exp_live  = 0;
        out_ready = 0;
        check("valid_after_hs", {31'b0, out_valid}, 32'd0);
        check("ready_after_hs", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_mod", {30'b0, mod_out}, 32'd0);
        check("rst_illegal", {31'b0, illegal_mod}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1;

        send(2'b00, 26'h00000B, 0, 1, 32'h000000B1);
        send(2'b01, 26'h0007FF, 0, 1, 32'h0000FFEF);
        send(2'b10, 26'h0000001, 0, 1, 32'h00000043);
        send(2'b10, 26'h0000000, 0, 1, 32'h00000000);
        send(2'b11, 26'($urandom), 0, 1, 32'h00000000);
        send(2'b01, 26'($urandom), 10, 0, 32'h0);

        @(negedge clk);
        in_valid = 1;
        mod_in   = 2'b10;
        info_in  = 26'h3FFFFFF;
        @(posedge clk);
        #1;
        in_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_data", data_out, 32'd0);
        check("midrst_mod", {30'b0, mod_out}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1;
        send(2'b10, 26'h2A5A5A5, 0, 0, 32'h0);

        for (int n = 0; n < 60; n++)
            send(2'($urandom), 26'($urandom), int'($urandom_range(0, 3)), 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
